sha256_unrolled_pipe: RTL and testbench
=======================================

Name: sha256_unrolled_pipe

Overview:
- Fully unrolled, one-round-per-clock SHA-256 compression pipeline for the Bitcoin miner.
- Parameter FINAL selects the personality:
  - FINAL=0: second-chunk stage. Compresses the 16-byte header tail, starting from the midstate.
  - FINAL=1: outer-hash stage. Compresses a 256-bit digest with the standard IV.
- One new message may enter per enabled clock; results emerge in order after a fixed latency.

Parameters:
- FINAL, 0, 0 = header-tail mode; 1 = outer-hash mode.
- BLOCK_W, FINAL?256:128, block_in width (derived; do not override).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- write_en  in  1  pipeline advance enable; 0 freezes every register
- digest_intial  in  256  FINAL=0 only: value added to the final state (midstate); H0 in [255:224]; ignored when FINAL=1
- digest_in  in  256  FINAL=0 only: starting working state a..h (a in [255:224]); ignored when FINAL=1
- block_in  in  BLOCK_W  message words, big-endian; W0 = MSBs
- digest_out  out  256  resulting hash; H0 in [255:224]
- valid_out  out  1  digest_out holds a result of real input

Behaviour:
- Message padding, FINAL=0:
  - W0..W3 = block_in, W4 = 0x80000000, W5..W14 = 0, W15 = 0x00000280 (640-bit header length).
- Message padding, FINAL=1:
  - W0..W7 = block_in, W8 = 0x80000000, W9..W14 = 0, W15 = 0x00000100.
- Initial state and final addend:
  - FINAL=0: initial state = digest_in; final addend = digest_intial.
  - FINAL=1: initial state and final addend = SHA-256 IV (6a09e667 … 5be0cd19).
- Pipeline structure:
  - 64 round stages. Stage r holds a..h after round r plus a 16-word schedule window.
  - FINAL=0: each stage also carries the 256-bit addend, so addend and data stay aligned.
- Timing:
  - On a rising CLK with write_en=1, every stage captures its predecessor; stage 0 captures the round-0 result of the current inputs.
  - With write_en=0, nothing changes, including valid_out.
  - digest_out = last-stage state + addend, word-wise mod 2^32, combinational from the last stage.
  - Latency: 64 enabled clocks from input sample to digest_out; throughput one hash per enabled clock.
- valid_out:
  - A 7-bit fill counter increments on each enabled clock, saturating at 64.
  - valid_out = (counter == 64).
  - Once set, valid_out stays 1 until reset; stalls do not clear it.
- Reset:
  - Clears the counter, all stage registers and valid_out.
  - digest_out then equals 0 + addend; this is don't-care while valid_out=0.
  - Reset mid-stream discards all in-flight work.
- All arithmetic is 32-bit modular, with standard σ0/σ1/Σ0/Σ1/Ch/Maj and the K table.

Optional Feature:
- SHA_OUT_REG_EN defined:
  - digest_out and valid_out are registered after the final add.
  - Latency becomes 65 enabled clocks; the register resets to 0 and holds when write_en=0.
  - The fill counter saturates at 65.
- SHA_OUT_REG_EN undefined: combinational output as above, latency 64.

Decomposition:
- Package sha256_pkg holds:
  - K[0:63] constant array and IV constant.
  - Padding words 0x80000000, 0x280, 0x100.
  - Functions ch, maj, bsig0, bsig1, ssig0, ssig1.
  - Typedef for the 8-word state.
- Sub-module sha256_round: one registered round plus schedule-window shift, enable-gated. It is instantiated 64× via generate with a per-stage K index parameter.

Test Plan:
- FINAL=1, block_in=256'h0, write_en held 1 → after 64 clocks, valid_out=1 and digest_out=256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925.
- Genesis-header chain:
  - FINAL=0 fed the software-computed midstate on both digest_in and digest_intial.
  - block_in = header bytes 64..79 (merkle tail, time, bits, nonce 0x7c2bac1d).
  - FINAL=0 output feeds FINAL=1.
  - Final digest = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000.
- Streaming: 100 consecutive distinct block_in values, write_en=1 → outputs 64 clocks later in order, each matching the C/Python model.
- Stall: toggle write_en pseudo-randomly → digest_out and valid_out frozen during 0 cycles; the result sequence is identical to the unstalled run.
- Reset: deassert RST at clock 30 of fill → valid_out=0 immediately; it needs 64 fresh enabled clocks to reassert.
- With SHA_OUT_REG_EN: repeat the zero-digest case → valid_out first at enabled clock 65, same digest value.

Source files
------------

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared SHA-256 constants, padding words, the 8-word state
//               type and the round/schedule bit functions used by the
//               unrolled compression pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    typedef logic [31:0] word_t;

    // First member lands in the MSBs, so a = [255:224] of a flat 256-bit bus.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    // Padding: leading '1' bit word, and the two message bit-lengths
    // (640-bit block header, 256-bit inner digest).
    localparam word_t PAD_ONE     = 32'h80000000;
    localparam word_t PAD_LEN_HDR = 32'h00000280;
    localparam word_t PAD_LEN_OUT = 32'h00000100;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ============================================================================
// Module      : sha256_round
// Description : One registered SHA-256 round plus a 16-word message schedule
//               window shift. All registers are gated by en_i.
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   en_i       in   advance enable
//   state_i    in   a..h before this round (a in [255:224])
//   win_i      in   W[r]..W[r+15], W[r] in [511:480]
//   addend_i   in   final addend travelling alongside the data
//   state_o    out  registered a..h after this round
//   win_o      out  registered W[r+1]..W[r+16]
//   addend_o   out  addend, registered when CARRY_ADDEND != 0
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_round
    import sha256_pkg::*;
#(
    parameter int RIDX         = 0,
    parameter int CARRY_ADDEND = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         en_i,
    input  logic [255:0] state_i,
    input  logic [511:0] win_i,
    input  logic [255:0] addend_i,
    output logic [255:0] state_o,
    output logic [511:0] win_o,
    output logic [255:0] addend_o
);

    state_t       w_cur;
    state_t       state_d;
    state_t       state_q;
    word_t        w_t1;
    word_t        w_t2;
    word_t        w_wnew;
    logic [511:0] win_d;
    logic [511:0] win_q;

    assign w_cur = state_t'(state_i);

    always_comb begin
        w_t1 = w_cur.h + bsig1(w_cur.e) + ch(w_cur.e, w_cur.f, w_cur.g)
             + K[RIDX] + win_i[511:480];
        w_t2 = bsig0(w_cur.a) + maj(w_cur.a, w_cur.b, w_cur.c);

        state_d   = w_cur;
        state_d.a = w_t1 + w_t2;
        state_d.b = w_cur.a;
        state_d.c = w_cur.b;
        state_d.d = w_cur.c;
        state_d.e = w_cur.d + w_t1;
        state_d.f = w_cur.e;
        state_d.g = w_cur.f;
        state_d.h = w_cur.g;

        // W[r+16] = s1(W[r+14]) + W[r+9] + s0(W[r+1]) + W[r]
        w_wnew = ssig1(win_i[63:32]) + win_i[223:192]
               + ssig0(win_i[479:448]) + win_i[511:480];
        win_d  = {win_i[479:0], w_wnew};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= '0;
            win_q   <= '0;
        end else if (en_i) begin
            state_q <= state_d;
            win_q   <= win_d;
        end
    end

    assign state_o = state_q;
    assign win_o   = win_q;

    generate
        if (CARRY_ADDEND != 0) begin : g_addend_reg
            logic [255:0] addend_q;
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    addend_q <= '0;
                end else if (en_i) begin
                    addend_q <= addend_i;
                end
            end
            assign addend_o = addend_q;
        end else begin : g_addend_pass
            // Constant addend needs no per-stage storage.
            assign addend_o = addend_i;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sha256_unrolled_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sha256_unrolled_pipe
// Description : Fully unrolled 64-stage SHA-256 compression pipeline, one
//               round per enabled clock, one message accepted per enabled
//               clock.
//               FINAL=0 : header-tail stage (16-byte block, midstate start)
//               FINAL=1 : outer-hash stage (256-bit digest, standard IV)
//               Optional macro SHA_OUT_REG_EN adds an output register after
//               the final add (latency 65 instead of 64).
//   CLK            in   clock, rising edge
//   RST            in   asynchronous active-low reset
//   write_en       in   pipeline advance enable; 0 freezes everything
//   digest_intial  in   final addend (midstate), FINAL=0 only
//   digest_in      in   starting working state a..h, FINAL=0 only
//   block_in       in   message words, W0 in the MSBs
//   digest_out     out  resulting hash, H0 in [255:224]
//   valid_out      out  digest_out holds a result of real input
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_unrolled_pipe
    import sha256_pkg::*;
#(
    parameter int FINAL   = 0,
    parameter int BLOCK_W = (FINAL != 0) ? 256 : 128
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               write_en,
    input  logic [255:0]       digest_intial,
    input  logic [255:0]       digest_in,
    input  logic [BLOCK_W-1:0] block_in,
    output logic [255:0]       digest_out,
    output logic               valid_out
);

`ifdef SHA_OUT_REG_EN
    localparam logic [6:0] c_FILL = 7'd65;
`else
    localparam logic [6:0] c_FILL = 7'd64;
`endif

    logic [511:0] w_msg;
    logic [255:0] w_state  [0:64];
    logic [511:0] w_win    [0:64];
    logic [255:0] w_addend [0:64];
    logic [255:0] w_sum;
    logic [6:0]   cnt_q;
    logic [6:0]   cnt_d;

    // Padded message block and pipeline entry values per personality.
    generate
        if (FINAL != 0) begin : g_outer
            assign w_msg       = {block_in, PAD_ONE, 192'd0, PAD_LEN_OUT};
            assign w_state[0]  = IV;
            assign w_addend[0] = IV;
        end else begin : g_tail
            assign w_msg       = {block_in, PAD_ONE, 320'd0, PAD_LEN_HDR};
            assign w_state[0]  = digest_in;
            assign w_addend[0] = digest_intial;
        end
    endgenerate

    assign w_win[0] = w_msg;

    generate
        for (genvar r = 0; r < 64; r++) begin : g_round
            sha256_round #(
                .RIDX         (r),
                .CARRY_ADDEND ((FINAL == 0) ? 1 : 0)
            ) u_round (
                .CLK      (CLK),
                .RST      (RST),
                .en_i     (write_en),
                .state_i  (w_state[r]),
                .win_i    (w_win[r]),
                .addend_i (w_addend[r]),
                .state_o  (w_state[r+1]),
                .win_o    (w_win[r+1]),
                .addend_o (w_addend[r+1])
            );
        end
    endgenerate

    generate
        for (genvar i = 0; i < 8; i++) begin : g_final_add
            assign w_sum[32*i +: 32] = w_state[64][32*i +: 32]
                                     + w_addend[64][32*i +: 32];
        end
    endgenerate

    // Fill counter: counts enabled clocks, saturates at the pipeline depth.
    always_comb begin
        cnt_d = cnt_q;
        if (write_en && (cnt_q != c_FILL)) begin
            cnt_d = cnt_q + 7'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign valid_out = (cnt_q == c_FILL);

`ifdef SHA_OUT_REG_EN
    logic [255:0] digest_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            digest_q <= '0;
        end else if (write_en) begin
            digest_q <= w_sum;
        end
    end

    assign digest_out = digest_q;
`else
    assign digest_out = w_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_unrolled_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_unrolled_pipe
// Description : Directed self-checking bench for both pipeline personalities:
//               zero-digest outer hash, genesis header chain, streaming,
//               random stalls and mid-fill reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_unrolled_pipe;

`ifdef SHA_OUT_REG_EN
    localparam int LAT = 65;
`else
    localparam int LAT = 64;
`endif

    localparam logic [31:0] TK [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] TIV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ZERO_DIG =
        256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;
    localparam logic [255:0] GENESIS =
        256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [511:0] HDR0 = {32'h01000000, 256'h0,
        224'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa};
    localparam logic [127:0] HDR_TAIL = 128'h4b1e5e4a29ab5f49ffff001d1dac2b7c;
    localparam logic [255:0] STREAM_S =
        256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         we  = 1'b0;
    logic [255:0] dig_init0 = '0;
    logic [255:0] dig_in0   = '0;
    logic [127:0] blk0      = '0;
    logic [255:0] blk1      = '0;
    logic [255:0] dout0;
    logic [255:0] dout1;
    logic         vout0;
    logic         vout1;

    int checks   = 0;
    int failures = 0;

    logic [255:0] midstate;
    logic [255:0] e0 [0:99];
    logic [255:0] e1 [0:99];

    always #5 CLK = ~CLK;

    sha256_unrolled_pipe #(.FINAL(0)) u_dut0 (
        .CLK           (CLK),
        .RST           (RST),
        .write_en      (we),
        .digest_intial (dig_init0),
        .digest_in     (dig_in0),
        .block_in      (blk0),
        .digest_out    (dout0),
        .valid_out     (vout0)
    );

    // Digest inputs tied to live signals to confirm FINAL=1 ignores them.
    sha256_unrolled_pipe #(.FINAL(1)) u_dut1 (
        .CLK           (CLK),
        .RST           (RST),
        .write_en      (we),
        .digest_intial (dig_init0),
        .digest_in     (dig_in0),
        .block_in      (blk1),
        .digest_out    (dout1),
        .valid_out     (vout1)
    );

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression: returns working state after 64 rounds.
    function automatic logic [255:0] compress(input logic [255:0] st,
                                              input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = st;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g))
               + TK[i] + w[i];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a, b, c, d, e, f, g, h};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    function automatic logic [255:0] hash0(input logic [255:0] init,
                                           input logic [255:0] addend,
                                           input logic [127:0] blk);
        return add8(compress(init, {blk, 32'h80000000, 320'h0, 32'h00000280}), addend);
    endfunction

    function automatic logic [255:0] hash1(input logic [255:0] blk);
        return add8(compress(TIV, {blk, 32'h80000000, 192'h0, 32'h00000100}), TIV);
    endfunction

    function automatic logic [127:0] f0(input int k);
        logic [31:0] kk;
        kk = k;
        return {kk * 32'h9e3779b9, ~kk, kk ^ 32'h5a5a5a5a, 32'h00001000 + kk};
    endfunction

    function automatic logic [255:0] f1(input int k);
        return {f0(k + 1000), f0(k)};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int acc;
        int iter;
        logic en_now;

        midstate = add8(compress(TIV, HDR0), TIV);
        for (int k = 0; k < 100; k++) begin
            e0[k] = hash0(STREAM_S, midstate, f0(k));
            e1[k] = hash1(f1(k));
        end

        // ---------------- reset state ----------------
        repeat (2) step();
        chk("rst_valid0", 256'(vout0), 256'(1'b0));
        chk("rst_valid1", 256'(vout1), 256'(1'b0));
        chk("rst_digest0", dout0, 256'h0);
`ifdef SHA_OUT_REG_EN
        chk("rst_digest1", dout1, 256'h0);
`else
        chk("rst_digest1", dout1, TIV);
`endif
        @(negedge CLK);
        RST = 1'b1;

        // ---------------- zero digest + genesis first hash ----------------
        dig_in0   = midstate;
        dig_init0 = midstate;
        blk0      = HDR_TAIL;
        blk1      = '0;
        we        = 1'b0;
        repeat (5) step();  // stalled clocks must not advance the fill counter
        we = 1'b1;
        repeat (LAT - 1) step();
        chk("fill_valid0_early", 256'(vout0), 256'(1'b0));
        chk("fill_valid1_early", 256'(vout1), 256'(1'b0));
        step();
        chk("fill_valid1", 256'(vout1), 256'(1'b1));
        chk("fill_valid0", 256'(vout0), 256'(1'b1));
        chk("zero_digest", dout1, ZERO_DIG);
        chk("genesis_first", dout0, hash0(midstate, midstate, HDR_TAIL));

        // Chain the first-stage output into the outer hash.
        blk1 = dout0;
        repeat (LAT) step();
        chk("genesis_final", dout1, GENESIS);

        // ---------------- streaming ----------------
        dig_in0   = STREAM_S;
        dig_init0 = midstate;
        for (int n = 0; n < 100 + LAT - 1; n++) begin
            if (n < 100) begin
                blk0 = f0(n);
                blk1 = f1(n);
            end
            step();
            if (n >= LAT - 1) begin
                chk("stream0", dout0, e0[n-LAT+1]);
                chk("stream1", dout1, e1[n-LAT+1]);
            end
        end

        // ---------------- random stalls ----------------
        acc  = 0;
        iter = 0;
        while (acc < LAT + 40 && iter < 2000) begin
            en_now = ($urandom_range(0, 2) != 0);
            we     = en_now;
            if (en_now) begin
                blk0 = f0(acc);
                blk1 = f1(acc);
            end else begin
                blk0 = ~f0(acc);  // junk while stalled must never be captured
                blk1 = ~f1(acc);
            end
            step();
            if (en_now) acc++;
            chk("stall_valid", 256'(vout0), 256'(1'b1));
            if (acc >= LAT && acc - LAT < 40) begin
                chk("stall0", dout0, e0[acc-LAT]);
                chk("stall1", dout1, e1[acc-LAT]);
            end
            iter++;
        end
        if (acc < LAT + 40) chk("stall_budget", 256'(acc), 256'(LAT + 40));

        // ---------------- reset mid-fill ----------------
        we   = 1'b1;
        blk0 = f0(0);
        RST  = 1'b0;
        #1;
        chk("async_rst_valid", 256'(vout0), 256'(1'b0));
        @(negedge CLK);
        RST = 1'b1;
        repeat (30) step();
        chk("refill30_valid", 256'(vout0), 256'(1'b0));
        RST = 1'b0;
        #1;
        chk("rst30_valid", 256'(vout0), 256'(1'b0));
        chk("rst30_digest", dout0, 256'h0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (LAT - 1) step();
        chk("refill_valid_early", 256'(vout0), 256'(1'b0));
        step();
        chk("refill_valid", 256'(vout0), 256'(1'b1));
        chk("refill_digest", dout0, e0[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
